// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with registered Gray output, binary/Gray parallel load and wrap flag
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset; clears b_o, g_o and wrap_o
//   en_i             count enable, one step per cycle
//   up_i             direction, 1 = increment, 0 = decrement (sampled only with en_i)
//   load_i           parallel load strobe, overrides en_i
//   load_is_gray_i   1 = load_val_i is Gray coded, 0 = binary
//   load_val_i       value to load
//   b_o              registered binary count
//   g_o              registered Gray count, always b_o ^ (b_o >> 1)
//   wrap_o           one-cycle pulse after a step taken at a limit (wrapped or blocked)
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic             load_is_gray_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] g_o,
    output logic             wrap_o
);
    logic [WIDTH-1:0] b_q, b_d, g_q, g_d, load_bin, step;
    logic             wrap_q, wrap_d, at_lim;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) load_bin[i] = ^(load_val_i >> i);
    end

    assign at_lim = up_i ? &b_q : ~|b_q;
    assign step   = up_i ? b_q + 1'b1 : b_q - 1'b1;

    // Gray is derived from the next binary value so both registers always agree;
    // a Gray load re-encodes to exactly load_val_i
    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        if (load_i) begin
            b_d = load_is_gray_i ? load_bin : load_val_i;
        end else if (en_i) begin
            wrap_d = at_lim;
            b_d    = (at_lim && SATURATE) ? b_q : step;
        end
        g_d = b_d ^ (b_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= '0;
            g_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign b_o    = b_q;
    assign g_o    = g_q;
    assign wrap_o = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: self-checking bench for gray_counter (4-bit wrap/saturate, width sweep 2/8/16)
module tb_gray_counter;
    typedef struct {
        logic ld, lg, en, up;
        logic [3:0] lv, eb, eg;
        logic ew;
    } vec_t;
    typedef struct {
        logic s;
        logic [3:0] b, g;
        logic w, cnt;
        string n;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ld = 1'b0, lg = 1'b0, en = 1'b0, up = 1'b0;
    logic [3:0] lv = '0;
    logic [3:0] b4, g4, bs, gs;
    logic w4, ws;
    logic en_s = 1'b0, one = 1'b1, zero = 1'b0;
    logic [1:0] lv2 = '0, b2, g2;
    logic [7:0] lv8 = '0, b8, g8;
    logic [15:0] lv16 = '0, b16, g16;
    logic w2, w8, w16;
    int compared = 0, mismatched = 0;
    exp_t q[$];
    vec_t tv[12];

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .SATURATE(1'b0)) d4 (.clk(clk), .rst_n(rst_n), .en_i(en), .up_i(up),
        .load_i(ld), .load_is_gray_i(lg), .load_val_i(lv), .b_o(b4), .g_o(g4), .wrap_o(w4));
    gray_counter #(.WIDTH(4), .SATURATE(1'b1)) d4s (.clk(clk), .rst_n(rst_n), .en_i(en), .up_i(up),
        .load_i(ld), .load_is_gray_i(lg), .load_val_i(lv), .b_o(bs), .g_o(gs), .wrap_o(ws));
    gray_counter #(.WIDTH(2)) d2 (.clk(clk), .rst_n(rst_n), .en_i(en_s), .up_i(one),
        .load_i(zero), .load_is_gray_i(zero), .load_val_i(lv2), .b_o(b2), .g_o(g2), .wrap_o(w2));
    gray_counter #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .en_i(en_s), .up_i(one),
        .load_i(zero), .load_is_gray_i(zero), .load_val_i(lv8), .b_o(b8), .g_o(g8), .wrap_o(w8));
    gray_counter #(.WIDTH(16)) d16 (.clk(clk), .rst_n(rst_n), .en_i(en_s), .up_i(one),
        .load_i(zero), .load_is_gray_i(zero), .load_val_i(lv16), .b_o(b16), .g_o(g16), .wrap_o(w16));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // drive one cycle of stimulus on the 4-bit pair; s selects the saturating instance for checking
    task automatic step(input logic s, input logic ld_v, input logic lg_v, input logic en_v, input logic up_v,
                        input logic [3:0] lv_v, input logic [3:0] eb, input logic [3:0] eg, input logic ew,
                        input string n);
        exp_t e;
        logic [3:0] pg;
        @(negedge clk);
        ld = ld_v; lg = lg_v; en = en_v; up = up_v; lv = lv_v;
        pg = s ? gs : g4;
        e.s = s; e.b = eb; e.g = eg; e.w = ew; e.cnt = en_v && !ld_v && !s; e.n = n;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({e.n, " b"}, e.s ? bs : b4, e.b);
        chk({e.n, " g"}, e.s ? gs : g4, e.g);
        chk({e.n, " wrap"}, e.s ? ws : w4, e.w);
        if (e.cnt) chk({e.n, " g one-bit"}, $countones((e.s ? gs : g4) ^ pg), 1);
    endtask

    task automatic sw(input string n, input int w, input logic [31:0] b, input logic [31:0] g,
                      input logic [31:0] pg, input logic wr, inout int m, inout int wc);
        int mask;
        logic ew;
        mask = (1 << w) - 1;
        ew = (m == mask);
        m = (m + 1) & mask;
        chk({n, " b"}, b, m);
        chk({n, " g"}, g, m ^ (m >> 1));
        chk({n, " g one-bit"}, $countones(g ^ pg), 1);
        chk({n, " wrap"}, {31'b0, wr}, {31'b0, ew});
        if (wr) wc++;
    endtask

    initial begin
        int m2 = 0, m8 = 0, m16 = 0, wc2 = 0, wc8 = 0, wc16 = 0;
        logic [15:0] p2, p8, p16;
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 4'd14, 4'd9,  1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd15, 4'd8,  1'b0};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd0,  1'b1};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd1,  4'd1,  1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd0,  1'b0};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd15, 4'd8,  1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd15, 4'd8,  1'b0};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 4'd9,  4'd13, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  4'd3,  4'd2,  1'b0};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd13, 4'd9,  4'd13, 1'b0};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd10, 4'd15, 1'b0};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  4'd9,  4'd13, 1'b0};

        #2;
        chk("reset b", b4, 0);
        chk("reset g", g4, 0);
        chk("reset wrap", w4, 0);
        chk("reset sat b", bs, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            step(1'b0, tv[i].ld, tv[i].lg, tv[i].en, tv[i].up, tv[i].lv, tv[i].eb, tv[i].eg, tv[i].ew,
                 $sformatf("vec%0d", i));

        @(posedge clk);
        #2;
        chk("pre-reset b", b4, 9);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset b", b4, 0);
        chk("async reset g", g4, 0);
        chk("async reset wrap", w4, 0);
        @(negedge clk);
        rst_n = 1'b1; ld = 1'b0; en = 1'b1; up = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("post-reset b", b4, 2);
        chk("post-reset g", g4, 3);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 4'd14, 4'd9, 1'b0, "sat load");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'd8, 1'b0, "sat up1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'd8, 1'b1, "sat up2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 4'd8, 1'b1, "sat up3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd14, 4'd9, 1'b0, "sat down");

        @(negedge clk);
        en = 1'b0;
        chk("sweep start b2", b2, 0);
        chk("sweep start b16", b16, 0);
        en_s = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            p2 = {14'b0, g2}; p8 = {8'b0, g8}; p16 = g16;
            @(posedge clk);
            #1;
            sw("w2", 2, b2, g2, p2, w2, m2, wc2);
            sw("w8", 8, b8, g8, p8, w8, m8, wc8);
            sw("w16", 16, b16, g16, p16, w16, m16, wc16);
            @(negedge clk);
        end
        en_s = 1'b0;
        chk("w2 wrap count", wc2, 16384);
        chk("w8 wrap count", wc8, 256);
        chk("w16 wrap count", wc16, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
